video_stream_gen: RTL and testbench
===================================

# video_stream_gen

AXI4-Stream video master that produces complete frames of a selectable test pattern on the camera-clock side, carrying tuser on start-of-frame and tlast on end-of-line with full tready backpressure. It is the transmitter for the capture path's AXI4-Stream video slave. It replaces the camera during bring-up, so the frame-buffer write path and the HDMI read-out can be exercised without a sensor.

## Interface
Parameters:
- H_ACTIVE, 640, pixels per line; must be a multiple of 8 and at least 8.
- V_ACTIVE, 480, lines per frame; must be at least 1.
- H_GAP, 16, idle cycles with tvalid low between lines; 0 is allowed.
- V_GAP, 64, idle cycles with tvalid low after the last line of a frame; 0 is allowed.

Ports:
- Cclk  in  1  single clock. All logic is in this domain.
- rstn  in  1  asynchronous, active-low reset.
- Enable  in  1  run request. Sampled at frame boundaries only.
- Pattern  in  2  pattern select. Latched at each frame start.
- m_axis_video_tdata  out  24  pixel as {c2[7:0], c1[7:0], c0[7:0]}.
- m_axis_video_tvalid  out  1  pixel valid.
- m_axis_video_tuser  out  1  start of frame, asserted with pixel (0,0) only.
- m_axis_video_tlast  out  1  end of line, asserted with pixel x = H_ACTIVE-1.
- m_axis_video_tready  in  1  slave ready.
- FrameDone  out  1  one-cycle pulse at the end of each V_GAP.
- Busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE.
  - LINE: emitting pixels.
  - HGAP: idle between lines.
  - VGAP: idle after the frame.
- Transitions:
  - IDLE → LINE when Enable = 1.
  - LINE → HGAP when the last pixel of a line is accepted and y < V_ACTIVE-1. If H_GAP = 0, go LINE → LINE instead.
  - LINE → VGAP when the last pixel of the last line is accepted.
  - HGAP → LINE after H_GAP cycles.
  - VGAP → LINE after V_GAP cycles if Enable = 1, otherwise VGAP → IDLE. FrameDone pulses on this exit. If V_GAP = 0, the exit happens in the cycle immediately following the last-pixel acceptance.
- Counters:
  - x is clog2(H_ACTIVE) bits and wraps to 0 after H_ACTIVE-1.
  - y is clog2(V_ACTIVE) bits and wraps to 0 at frame end.
  - gap counter is clog2(max(H_GAP,V_GAP,1)+1) bits.
  - frame counter is 8 bits, increments at each frame end, and wraps 255 → 0.
- Handshake:
  - A pixel is accepted when tvalid & tready.
  - While tvalid = 1 and tready = 0, tdata, tuser, and tlast hold stable and tvalid stays high.
  - tvalid never depends combinationally on tready.
- Enable deassert mid-frame: the current frame completes, including V_GAP, and the FSM then goes to IDLE. There are no partial frames.
- Patterns, latched into pat_q on the IDLE/VGAP → LINE transition:
  - 0, colour bars: 8 bars, each H_ACTIVE/8 wide. Bars in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. The bar index comes from a counter, not a divider.
  - 1, gradient: {x[7:0], y[7:0], x[7:0]^y[7:0]}.
  - 2, checker: FFFFFF when x[3]^y[3] = 0, else 000000.
  - 3, flat: {frame[7:0], ~frame[7:0], frame[7:0]}.
- Reset (asynchronous, any time including mid-line):
  - State goes to IDLE.
  - All outputs go to 0: tdata = 24'h000000, tvalid, tuser, tlast, FrameDone, and Busy all 0.
  - x, y, gap counter, frame counter, bar counter, and pat_q are all cleared.

## Timing
- All outputs are registered.
- The first tvalid appears on the first Cclk edge after IDLE sees Enable = 1, carrying pixel (0,0) with tuser = 1.
- With tready held at 1, one pixel is accepted per cycle.
- Line period is H_ACTIVE + H_GAP cycles. Frame period is V_ACTIVE·(H_ACTIVE+H_GAP) − H_GAP + V_GAP + 1 cycles, with the extra cycle being the VGAP exit.
- The next pixel is presented on the edge at which the current pixel is accepted. There are no bubbles inside a line.
- tuser and tlast both equal 1 only when H_ACTIVE = 1, which is excluded, so they never coincide.
- Busy goes high on the same edge that tvalid first rises. It goes low on the edge entering IDLE.

## Structure
- Shared package video_stream_pkg holds:
  - the state enum: IDLE, LINE, HGAP, VGAP;
  - the 8 colour-bar constants;
  - pattern code localparams: PAT_BARS = 0, PAT_GRAD = 1, PAT_CHECK = 2, PAT_FLAT = 3.
- One sub-module, vsg_pattern: a registered pixel function taking inputs (pat_q, bar index, x, y, frame) and producing tdata.
- Top level contains the FSM, counters, and handshake hold logic. Expected size is about 200 lines.

## Test plan
- H_ACTIVE=8, V_ACTIVE=2, H_GAP=2, V_GAP=3, Pattern=0, tready=1:
  - tdata per line is exactly the 8 bar constants.
  - tuser appears only on the first beat; tlast appears on beats 8 and 16.
  - The 2-cycle tvalid gap occurs between lines.
  - FrameDone occurs 4 cycles after beat 16.
- Random tready (50%), Pattern=1: each accepted beat equals {x, y, x^y} in raster order. tdata, tuser, and tlast never change while tvalid & !tready. No beats are lost or duplicated.
- H_GAP=0, V_GAP=0, Enable held high: back-to-back lines with no gap. The next frame's tuser beat is presented on the cycle after the FrameDone pulse.
- Enable dropped at mid-frame line 1: the frame completes (all V_ACTIVE tlasts), then FrameDone, then IDLE with Busy = 0. No further tvalid appears.
- rstn asserted while tvalid = 1 and tready = 0: all outputs go to 0 immediately. After release with Enable = 1, the stream restarts at (0,0) with tuser = 1. Pattern=3 shows frame = 0, i.e. tdata = 00FF00.

Source files
------------

// File: rtl/video_stream_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern generator.
package video_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    HGAP = 2'd2,
    VGAP = 2'd3
  } vsg_state_t;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_GRAD  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      3'd7:    c = BAR_BLACK;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_stream_gen_pattern.sv
// Registered pixel function: computes the colour of the pixel about to be
// presented and captures it when the top level loads a new beat.
module vsg_pattern
  import video_stream_pkg::*;
(
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        load,
  input  logic [1:0]  pat,
  input  logic [2:0]  bar,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  frame,
  output logic [23:0] tdata
);

  logic [23:0] pix_s;

  // Colour selection for the requested pattern.
  always_comb begin
    pix_s = 24'h000000;
    case (pat)
      PAT_BARS:  pix_s = bar_colour(bar);
      PAT_GRAD:  pix_s = {x, y, x ^ y};
      PAT_CHECK: begin
        if ((x[3] ^ y[3]) == 1'b0) begin
          pix_s = 24'hFFFFFF;
        end else begin
          pix_s = 24'h000000;
        end
      end
      PAT_FLAT:  pix_s = {frame, ~frame, frame};
      default:   pix_s = 24'h000000;
    endcase
  end

  // Pixel register; holds while the sink stalls.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      tdata <= 24'h000000;
    end else if (load) begin
      tdata <= pix_s;
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// AXI4-Stream video master producing whole frames of a selectable test
// pattern with tuser on start-of-frame and tlast on end-of-line.
module video_stream_gen
  import video_stream_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_GAP    = 16,
  parameter int V_GAP    = 64
) (
  input  logic        Cclk,
  input  logic        rstn,
  input  logic        Enable,
  input  logic [1:0]  Pattern,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  input  logic        m_axis_video_tready,
  output logic        FrameDone,
  output logic        Busy
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int GMAX  = (H_GAP > V_GAP) ? ((H_GAP > 1) ? H_GAP : 1)
                                        : ((V_GAP > 1) ? V_GAP : 1);
  localparam int GW    = $clog2(GMAX + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [GW-1:0]  HG_LAST = GW'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam logic [GW-1:0]  VG_END  = GW'(V_GAP);
  localparam logic [GW-1:0]  VG_PRE  = GW'((V_GAP > 0) ? V_GAP - 1 : 0);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BAR_W - 1);

  vsg_state_t     state_r, state_n_s;
  logic [XW-1:0]  x_r, x_n_s;
  logic [YW-1:0]  y_r, y_n_s;
  logic [GW-1:0]  gap_r, gap_n_s;
  logic [7:0]     frame_r, frame_n_s;
  logic [2:0]     bar_r, bar_n_s;
  logic [BCW-1:0] bcnt_r, bcnt_n_s;
  logic [1:0]     pat_r, pat_n_s;
  logic           tvalid_r, tvalid_n_s;
  logic           tuser_r, tuser_n_s;
  logic           tlast_r, tlast_n_s;
  logic           fdone_r, fdone_n_s;
  logic           busy_r;
  logic           load_s, drop_s;
  logic           accept_s, x_last_s, y_last_s;
  logic [7:0]     x8_s, y8_s;

  assign accept_s = tvalid_r & m_axis_video_tready;
  assign x_last_s = (x_r == X_LAST);
  assign y_last_s = (y_r == Y_LAST);
  assign x8_s     = 8'(x_n_s);
  assign y8_s     = 8'(y_n_s);

  // State register.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state decode; Enable only matters in IDLE and at the VGAP exit.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (Enable) begin
          state_n_s = LINE;
        end else begin
          state_n_s = IDLE;
        end
      end
      LINE: begin
        if (accept_s && x_last_s && y_last_s) begin
          state_n_s = VGAP;
        end else if (accept_s && x_last_s && (H_GAP > 0)) begin
          state_n_s = HGAP;
        end else begin
          state_n_s = LINE;
        end
      end
      HGAP: begin
        if (gap_r == HG_LAST) begin
          state_n_s = LINE;
        end else begin
          state_n_s = HGAP;
        end
      end
      VGAP: begin
        if ((gap_r == VG_END) && Enable) begin
          state_n_s = LINE;
        end else if (gap_r == VG_END) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = VGAP;
        end
      end
      default: state_n_s = IDLE;
    endcase
  end

  // Datapath decode: which beat to load next, counter updates, flag values.
  always_comb begin
    load_s    = 1'b0;
    drop_s    = 1'b0;
    x_n_s     = x_r;
    y_n_s     = y_r;
    bar_n_s   = bar_r;
    bcnt_n_s  = bcnt_r;
    pat_n_s   = pat_r;
    gap_n_s   = gap_r;
    frame_n_s = frame_r;
    fdone_n_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (Enable) begin
          load_s   = 1'b1;
          x_n_s    = {XW{1'b0}};
          y_n_s    = {YW{1'b0}};
          bar_n_s  = 3'd0;
          bcnt_n_s = {BCW{1'b0}};
          pat_n_s  = Pattern;
        end else begin
          drop_s = 1'b1;
        end
      end
      LINE: begin
        if (accept_s && !x_last_s) begin
          load_s = 1'b1;
          x_n_s  = x_r + XW'(1'b1);
          // Bar index advances every BAR_W pixels without a divider.
          if (bcnt_r == BC_LAST) begin
            bcnt_n_s = {BCW{1'b0}};
            bar_n_s  = bar_r + 3'd1;
          end else begin
            bcnt_n_s = bcnt_r + BCW'(1'b1);
          end
        end else if (accept_s && !y_last_s && (H_GAP == 0)) begin
          load_s   = 1'b1;
          x_n_s    = {XW{1'b0}};
          y_n_s    = y_r + YW'(1'b1);
          bar_n_s  = 3'd0;
          bcnt_n_s = {BCW{1'b0}};
        end else if (accept_s && !y_last_s) begin
          drop_s  = 1'b1;
          gap_n_s = {GW{1'b0}};
        end else if (accept_s) begin
          drop_s    = 1'b1;
          gap_n_s   = {GW{1'b0}};
          x_n_s     = {XW{1'b0}};
          y_n_s     = {YW{1'b0}};
          frame_n_s = frame_r + 8'd1;
          fdone_n_s = (V_GAP == 0);
        end else begin
          load_s = 1'b0;
        end
      end
      HGAP: begin
        if (gap_r == HG_LAST) begin
          load_s   = 1'b1;
          x_n_s    = {XW{1'b0}};
          y_n_s    = y_r + YW'(1'b1);
          bar_n_s  = 3'd0;
          bcnt_n_s = {BCW{1'b0}};
        end else begin
          gap_n_s = gap_r + GW'(1'b1);
        end
      end
      VGAP: begin
        // FrameDone is registered, so it is raised one cycle ahead of the exit.
        if ((gap_r == VG_END) && Enable) begin
          load_s   = 1'b1;
          x_n_s    = {XW{1'b0}};
          y_n_s    = {YW{1'b0}};
          bar_n_s  = 3'd0;
          bcnt_n_s = {BCW{1'b0}};
          pat_n_s  = Pattern;
        end else if (gap_r == VG_END) begin
          drop_s = 1'b1;
        end else begin
          gap_n_s   = gap_r + GW'(1'b1);
          fdone_n_s = (gap_r == VG_PRE);
        end
      end
      default: drop_s = 1'b1;
    endcase

    if (load_s) begin
      tvalid_n_s = 1'b1;
      tuser_n_s  = (x_n_s == {XW{1'b0}}) && (y_n_s == {YW{1'b0}});
      tlast_n_s  = (x_n_s == X_LAST);
    end else if (drop_s) begin
      tvalid_n_s = 1'b0;
      tuser_n_s  = 1'b0;
      tlast_n_s  = 1'b0;
    end else begin
      tvalid_n_s = tvalid_r;
      tuser_n_s  = tuser_r;
      tlast_n_s  = tlast_r;
    end
  end

  // Counters and registered stream/status outputs.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
      gap_r    <= {GW{1'b0}};
      frame_r  <= 8'd0;
      bar_r    <= 3'd0;
      bcnt_r   <= {BCW{1'b0}};
      pat_r    <= 2'd0;
      tvalid_r <= 1'b0;
      tuser_r  <= 1'b0;
      tlast_r  <= 1'b0;
      fdone_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      x_r      <= x_n_s;
      y_r      <= y_n_s;
      gap_r    <= gap_n_s;
      frame_r  <= frame_n_s;
      bar_r    <= bar_n_s;
      bcnt_r   <= bcnt_n_s;
      pat_r    <= pat_n_s;
      tvalid_r <= tvalid_n_s;
      tuser_r  <= tuser_n_s;
      tlast_r  <= tlast_n_s;
      fdone_r  <= fdone_n_s;
      busy_r   <= (state_n_s != IDLE);
    end
  end

  vsg_pattern u_pattern (
    .Cclk  (Cclk),
    .rstn  (rstn),
    .load  (load_s),
    .pat   (pat_n_s),
    .bar   (bar_n_s),
    .x     (x8_s),
    .y     (y8_s),
    .frame (frame_n_s),
    .tdata (m_axis_video_tdata)
  );

  assign m_axis_video_tvalid = tvalid_r;
  assign m_axis_video_tuser  = tuser_r;
  assign m_axis_video_tlast  = tlast_r;
  assign FrameDone           = fdone_r;
  assign Busy                = busy_r;

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: two instances with different
// geometry, a vector table, a scoreboard under random backpressure, and
// hand-written reset/enable sequences.
module tb_video_stream_gen;

  logic Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  logic        rstn;
  logic        a_en, a_rdy, b_en, b_rdy;
  logic [1:0]  a_pat, b_pat;
  logic [23:0] a_d, b_d;
  logic        a_v, a_u, a_l, a_fd, a_busy;
  logic        b_v, b_u, b_l, b_fd, b_busy;

  int checks   = 0;
  int failures = 0;

  video_stream_gen #(.H_ACTIVE(8), .V_ACTIVE(2), .H_GAP(2), .V_GAP(3)) u_a (
    .Cclk(Cclk), .rstn(rstn), .Enable(a_en), .Pattern(a_pat),
    .m_axis_video_tdata(a_d), .m_axis_video_tvalid(a_v),
    .m_axis_video_tuser(a_u), .m_axis_video_tlast(a_l),
    .m_axis_video_tready(a_rdy), .FrameDone(a_fd), .Busy(a_busy)
  );

  video_stream_gen #(.H_ACTIVE(16), .V_ACTIVE(4), .H_GAP(0), .V_GAP(0)) u_b (
    .Cclk(Cclk), .rstn(rstn), .Enable(b_en), .Pattern(b_pat),
    .m_axis_video_tdata(b_d), .m_axis_video_tvalid(b_v),
    .m_axis_video_tuser(b_u), .m_axis_video_tlast(b_l),
    .m_axis_video_tready(b_rdy), .FrameDone(b_fd), .Busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference pixel computed straight from the pattern definitions.
  function automatic logic [23:0] ref_pix(input int pat, input int x, input int y,
                                          input int f, input int h);
    logic [7:0] xb, yb, fb;
    xb = 8'(x);
    yb = 8'(y);
    fb = 8'(f);
    case (pat)
      0: return bar_rgb(x / (h / 8));
      1: return {xb, yb, xb ^ yb};
      2: return ((((x >> 3) ^ (y >> 3)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
      default: return {fb, ~fb, fb};
    endcase
  endfunction

  task automatic do_reset();
    a_en = 1'b0; b_en = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge Cclk);
    #1 rstn = 1'b1;
    @(posedge Cclk);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        v;
    logic        u;
    logic        l;
    logic [23:0] d;
    logic        fd;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  vec_t  vec [24];
  beat_t exp_q [$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted, fd_cnt, n_sof;
    logic done, have_prev, p_v, p_u, p_l, p_r;
    logic [23:0] p_d;
    beat_t bt;

    // Expected cycle table for an 8x2 frame, HGAP 2, VGAP 3, Enable dropped on line 1.
    for (int k = 0; k < 24; k++) begin
      vec[k].en   = (k < 12);
      vec[k].v    = (k < 8) || (k >= 10 && k < 18);
      vec[k].u    = (k == 0);
      vec[k].l    = (k == 7) || (k == 17);
      vec[k].d    = (k < 8) ? bar_rgb(k) : ((k >= 10 && k < 18) ? bar_rgb(k - 10) : 24'h0);
      vec[k].fd   = (k == 21);
      vec[k].busy = (k < 22);
    end

    rstn = 1'b0;
    a_en = 1'b0; b_en = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    a_pat = 2'd0; b_pat = 2'd0;
    @(posedge Cclk);
    #1;
    chk("reset_outputs_a", {3'b000, a_d, a_v, a_u, a_l, a_fd, a_busy}, 32'h0);
    chk("reset_outputs_b", {3'b000, b_d, b_v, b_u, b_l, b_fd, b_busy}, 32'h0);
    rstn = 1'b1;
    @(posedge Cclk);
    #1;

    // ---- Test 1: colour bars, tready=1, table driven ----
    a_pat = 2'd0; a_rdy = 1'b1; a_en = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge Cclk);
      #1;
      chk($sformatf("t1_tvalid[%0d]", k), a_v, vec[k].v);
      chk($sformatf("t1_framedone[%0d]", k), a_fd, vec[k].fd);
      chk($sformatf("t1_busy[%0d]", k), a_busy, vec[k].busy);
      if (vec[k].v) begin
        chk($sformatf("t1_tdata[%0d]", k), a_d, vec[k].d);
        chk($sformatf("t1_tuser[%0d]", k), a_u, vec[k].u);
        chk($sformatf("t1_tlast[%0d]", k), a_l, vec[k].l);
      end
      a_en = vec[k].en;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge Cclk);
      #1;
      chk("t1_idle_tvalid", a_v, 1'b0);
      chk("t1_idle_busy", a_busy, 1'b0);
    end

    // ---- Test 2: gradient under random backpressure, scoreboard ----
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 16; x++) begin
          bt.d = ref_pix(1, x, y, f, 16);
          bt.u = (x == 0) && (y == 0);
          bt.l = (x == 15);
          exp_q.push_back(bt);
        end
    b_pat = 2'd1; b_en = 1'b1; b_rdy = 1'b0;
    have_prev = 1'b0; p_v = 1'b0; p_u = 1'b0; p_l = 1'b0; p_r = 1'b0; p_d = 24'h0;
    accepted = 0; fd_cnt = 0; done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge Cclk);
      #1;
      if (have_prev && p_v && !p_r) begin
        chk("t2_hold_tvalid", b_v, 1'b1);
        chk("t2_hold_tdata", b_d, p_d);
        chk("t2_hold_tuser", b_u, p_u);
        chk("t2_hold_tlast", b_l, p_l);
      end
      if (b_fd) fd_cnt++;
      p_v = b_v; p_d = b_d; p_u = b_u; p_l = b_l; have_prev = 1'b1;
      b_rdy = 1'($urandom_range(0, 1));
      p_r = b_rdy;
      if (b_v && b_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL t2_extra_beat: actual=beat 0x%0h required=no beat", b_d);
        end else begin
          bt = exp_q.pop_front();
          chk($sformatf("t2_tdata[%0d]", accepted), b_d, bt.d);
          chk($sformatf("t2_tuser[%0d]", accepted), b_u, bt.u);
          chk($sformatf("t2_tlast[%0d]", accepted), b_l, bt.l);
        end
        accepted++;
        if (accepted == 84) b_en = 1'b0;
      end
      if (exp_q.size() == 0 && !b_busy && accepted > 0) done = 1'b1;
    end
    b_rdy = 1'b0;
    chk("t2_completed_in_budget", done, 1'b1);
    chk("t2_beats_missing", exp_q.size(), 0);
    chk("t2_framedone_count", fd_cnt, 2);
    for (int k = 0; k < 5; k++) begin
      @(posedge Cclk);
      #1;
      chk("t2_idle_tvalid", b_v, 1'b0);
      chk("t2_idle_busy", b_busy, 1'b0);
    end

    // ---- Test 3: HGAP=0/VGAP=0 back-to-back, checker then flat ----
    do_reset();
    b_rdy = 1'b1; b_pat = 2'd2; b_en = 1'b1;
    for (int t = 0; t < 2 * 65 + 2; t++) begin
      int f, r;
      @(posedge Cclk);
      #1;
      f = t / 65;
      r = t % 65;
      if (t < 2 * 65) begin
        chk($sformatf("t3_busy[%0d]", t), b_busy, 1'b1);
        if (r < 64) begin
          chk($sformatf("t3_tvalid[%0d]", t), b_v, 1'b1);
          chk($sformatf("t3_framedone[%0d]", t), b_fd, 1'b0);
          chk($sformatf("t3_tdata[%0d]", t), b_d, ref_pix((f == 0) ? 2 : 3, r % 16, r / 16, f, 16));
          chk($sformatf("t3_tuser[%0d]", t), b_u, (r == 0));
          chk($sformatf("t3_tlast[%0d]", t), b_l, (r % 16 == 15));
        end else begin
          chk($sformatf("t3_tvalid[%0d]", t), b_v, 1'b0);
          chk($sformatf("t3_framedone[%0d]", t), b_fd, 1'b1);
        end
      end else begin
        chk($sformatf("t3_tvalid[%0d]", t), b_v, 1'b0);
        chk($sformatf("t3_busy[%0d]", t), b_busy, 1'b0);
        chk($sformatf("t3_framedone[%0d]", t), b_fd, 1'b0);
      end
      if (t == 3) b_pat = 2'd3;
      if (t == 65 + 5) b_en = 1'b0;
    end

    // ---- Test 4: reset while stalled mid-line, flat pattern ----
    do_reset();
    a_pat = 2'd3; a_rdy = 1'b1; a_en = 1'b1;
    n_sof = 0;
    for (int c = 0; c < 200 && n_sof < 2; c++) begin
      @(posedge Cclk);
      #1;
      if (a_v && a_u) begin
        n_sof++;
        chk($sformatf("t4_flat_sof%0d", n_sof), a_d, (n_sof == 1) ? 24'h00FF00 : 24'h01FE01);
      end
    end
    chk("t4_second_frame_seen", n_sof, 2);
    a_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge Cclk);
      #1;
      chk("t4_stall_tvalid", a_v, 1'b1);
      chk("t4_stall_tuser", a_u, 1'b1);
      chk("t4_stall_tdata", a_d, 24'h01FE01);
    end
    #2 rstn = 1'b0;
    #1;
    chk("t4_async_reset_outputs", {3'b000, a_d, a_v, a_u, a_l, a_fd, a_busy}, 32'h0);
    @(negedge Cclk);
    rstn = 1'b1;
    a_rdy = 1'b1;
    @(posedge Cclk);
    #1;
    chk("t4_restart_tvalid", a_v, 1'b1);
    chk("t4_restart_tuser", a_u, 1'b1);
    chk("t4_restart_tdata", a_d, 24'h00FF00);
    chk("t4_restart_busy", a_busy, 1'b1);
    a_en = 1'b0;
    repeat (40) @(posedge Cclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
